// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: mid-bit sampling from an internal baud counter,
// 5..9 data bits, 1 or 2 stop bits, valid/ack handshake. Parity via UART_RX_PARITY_EN.
module uart_rx_param #(
   parameter int CLK_DIV   = 10416,
   parameter int DATA_BITS = 8,
   parameter int STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 data_bit,
`ifdef UART_RX_PARITY_EN
   input  logic                 parity_odd,
`endif
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   input  logic                 data_ack,
   output logic                 overrun,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 busy,
   output logic [3:0]           count
);

   localparam int            CW        = $clog2(CLK_DIV);
   localparam logic [CW-1:0] HALF_TGT  = CW'(CLK_DIV / 2 - 1);
   localparam logic [CW-1:0] FULL_TGT  = CW'(CLK_DIV - 1);
   localparam logic [3:0]    LAST_BIT  = 4'(DATA_BITS - 1);
   localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BREAK
   } state_t;

   state_t                 state;
   logic                   sync1;
   logic                   rx_s;
   logic                   rx_d;
   logic [CW-1:0]          baud_cnt;
   logic [CW-1:0]          baud_tgt;
   logic [DATA_BITS-1:0]   shift_reg;
   logic                   stop_cnt;
   logic                   sample;
   logic                   fall;
   logic                   commit;

`ifdef UART_RX_PARITY_EN
   logic                   par_bad;
`else
   assign parity_err = 1'b0;
`endif

   // Two-flop synchroniser plus one delay stage for falling-edge detection;
   // all reset high so a reset never looks like a start edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b1;
         rx_s  <= 1'b1;
         rx_d  <= 1'b1;
      end else begin
         sync1 <= data_bit;
         rx_s  <= sync1;
         rx_d  <= rx_s;
      end
   end

   assign sample = (baud_cnt == baud_tgt);
   assign fall   = rx_d & ~rx_s;
   assign commit = (state == STOP) && sample && rx_s && (stop_cnt == LAST_STOP);

   // Frame FSM and handshake; the word lands in data_out on the last good stop sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         baud_cnt   <= '0;
         baud_tgt   <= HALF_TGT;
         shift_reg  <= '0;
         stop_cnt   <= 1'b0;
         data_out   <= '0;
         data_valid <= 1'b0;
         overrun    <= 1'b0;
         frame_err  <= 1'b0;
         busy       <= 1'b0;
         count      <= 4'd0;
`ifdef UART_RX_PARITY_EN
         parity_err <= 1'b0;
         par_bad    <= 1'b0;
`endif
      end else begin
         frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err <= 1'b0;
`endif
         baud_cnt  <= baud_cnt + 1'b1;

         case (state)
            IDLE: begin
               if (fall) begin
                  state    <= START;
                  busy     <= 1'b1;
                  baud_cnt <= '0;
                  baud_tgt <= HALF_TGT;
                  count    <= 4'd0;
               end
            end
            START: begin
               if (sample) begin
                  baud_cnt <= '0;
                  if (!rx_s) begin
                     state    <= DATA;
                     baud_tgt <= FULL_TGT;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            DATA: begin
               if (sample) begin
                  baud_cnt  <= '0;
                  shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
                  count     <= count + 4'd1;
                  if (count == LAST_BIT) begin
                     stop_cnt <= 1'b0;
`ifdef UART_RX_PARITY_EN
                     state    <= PARITY;
`else
                     state    <= STOP;
`endif
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (sample) begin
                  baud_cnt <= '0;
                  par_bad  <= rx_s ^ (^shift_reg) ^ parity_odd;
                  state    <= STOP;
               end
            end
`endif
            STOP: begin
               if (sample) begin
                  baud_cnt <= '0;
                  if (!rx_s) begin
                     frame_err <= 1'b1;
                     state     <= BREAK;
                  end else if (stop_cnt == LAST_STOP) begin
                     state <= IDLE;
                     busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                     parity_err <= par_bad;
`endif
                  end else begin
                     stop_cnt <= stop_cnt + 1'b1;
                  end
               end
            end
            BREAK: begin
               if (rx_s) begin
                  state    <= IDLE;
                  busy     <= 1'b0;
                  baud_cnt <= '0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase

         // An ack landing with a commit is consumed by the new word, so overrun holds.
         if (commit) begin
            data_out   <= shift_reg;
            data_valid <= 1'b1;
            if (data_valid && !data_ack) begin
               overrun <= 1'b1;
            end
         end else if (data_ack && data_valid) begin
            data_valid <= 1'b0;
            overrun    <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param (CLK_DIV=16, 8 data bits, 1 stop bit).
// Define UART_RX_PARITY_EN for both bench and RTL to exercise the parity path.
module tb_uart_rx_param;

   localparam int BIT_CLKS = 16;
`ifdef UART_RX_PARITY_EN
   localparam int PAR_BITS = 1;
`else
   localparam int PAR_BITS = 0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       data_bit;
   logic       data_ack;
   logic [7:0] data_out;
   logic       data_valid;
   logic       overrun;
   logic       frame_err;
   logic       parity_err;
   logic       busy;
   logic [3:0] count;
`ifdef UART_RX_PARITY_EN
   logic       parity_odd;
`endif

   typedef struct packed {
      logic [7:0] data;
      logic       perr;
   } exp_t;

   exp_t       exp_q[$];
   int         vectors     = 0;
   int         miscompares = 0;
   int         ferr_cycles = 0;
   int         perr_cycles = 0;
   logic       prev_valid  = 1'b0;
   logic [7:0] prev_out    = 8'd0;

   uart_rx_param #(
      .CLK_DIV   (16),
      .DATA_BITS (8),
      .STOP_BITS (1)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .data_bit   (data_bit),
`ifdef UART_RX_PARITY_EN
      .parity_odd (parity_odd),
`endif
      .data_out   (data_out),
      .data_valid (data_valid),
      .data_ack   (data_ack),
      .overrun    (overrun),
      .frame_err  (frame_err),
      .parity_err (parity_err),
      .busy       (busy),
      .count      (count)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
      end
   endtask

   // Monitor: a new word is a rising data_valid or a changed data_out while valid.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (frame_err) ferr_cycles++;
      if (parity_err) perr_cycles++;
      if (data_valid && (!prev_valid || data_out != prev_out)) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL unexpected_word: got 0x%0h, want none", data_out);
         end else begin
            e = exp_q.pop_front();
            check_output("word", 32'(data_out), 32'(e.data));
            check_output("word_parity_err", 32'(parity_err), 32'(e.perr));
         end
      end
      prev_valid = data_valid;
      prev_out   = data_out;
   end

   task automatic send_frame(input logic [7:0] data, input logic par_bit, input logic stop_val);
      data_bit = 1'b0;
      repeat (BIT_CLKS) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         data_bit = data[i];
         repeat (BIT_CLKS) @(negedge clk);
      end
      if (PAR_BITS != 0) begin
         data_bit = par_bit;
         repeat (BIT_CLKS) @(negedge clk);
      end
      data_bit = stop_val;
      repeat (BIT_CLKS) @(negedge clk);
   endtask

   task automatic apply_stimulus(input logic [7:0] data, input logic par_bit, input logic stop_val,
                                 input logic expect_word, input logic expect_perr);
      if (expect_word) exp_q.push_back({data, expect_perr});
      send_frame(data, par_bit, stop_val);
   endtask

   task automatic pulse_ack();
      data_ack = 1'b1;
      @(negedge clk);
      data_ack = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int lat;
      int t;
      int ferr_before;
      int perr_before;
      logic seen_busy;

      rst_n    = 1'b0;
      data_bit = 1'b1;
      data_ack = 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_odd = 1'b0;
`endif
      repeat (3) @(negedge clk);
      check_output("reset_data_out", 32'(data_out), 32'h0);
      check_output("reset_valid", 32'(data_valid), 32'h0);
      check_output("reset_overrun", 32'(overrun), 32'h0);
      check_output("reset_busy", 32'(busy), 32'h0);
      check_output("reset_count", 32'(count), 32'h0);
      check_output("reset_errs", 32'({frame_err, parity_err}), 32'h0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // Single frame, never acked; latency measured from the start edge.
      lat = 0;
      fork
         apply_stimulus(8'hA5, 1'b0, 1'b1, 1'b1, 1'b0);
         begin
            while (!data_valid && lat < 300) begin
               @(negedge clk);
               lat++;
            end
         end
      join
      check_output("a5_latency_in_window", 32'(lat >= 150 && lat <= 165), 32'h1);
      check_output("a5_count", 32'(count), 32'h8);
      check_output("a5_valid", 32'(data_valid), 32'h1);
      check_output("a5_no_frame_err", 32'(ferr_cycles), 32'h0);
      repeat (20) @(negedge clk);

      // Back-to-back frames without ack produce an overrun.
      pulse_ack();
      check_output("ack_clears_valid", 32'(data_valid), 32'h0);
      apply_stimulus(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0);
      apply_stimulus(8'h81, 1'b1, 1'b1, 1'b1, 1'b0);
      repeat (4) @(negedge clk);
      check_output("b2b_data_out", 32'(data_out), 32'h81);
      check_output("b2b_valid", 32'(data_valid), 32'h1);
      check_output("b2b_overrun", 32'(overrun), 32'h1);
      pulse_ack();
      check_output("ack_valid_low", 32'(data_valid), 32'h0);
      check_output("ack_overrun_low", 32'(overrun), 32'h0);
      repeat (20) @(negedge clk);

      // Five-clock low glitch on the idle line.
      ferr_before = ferr_cycles;
      perr_before = perr_cycles;
      seen_busy   = 1'b0;
      t           = 0;
      fork
         begin
            data_bit = 1'b0;
            repeat (5) @(negedge clk);
            data_bit = 1'b1;
         end
         begin
            while (t < 40 && !(seen_busy && !busy)) begin
               @(negedge clk);
               t++;
               if (busy) seen_busy = 1'b1;
            end
         end
      join
      check_output("glitch_saw_busy", 32'(seen_busy), 32'h1);
      check_output("glitch_busy_drop_in_12", 32'(t <= 12), 32'h1);
      repeat (20) @(negedge clk);
      check_output("glitch_no_valid", 32'(data_valid), 32'h0);
      check_output("glitch_no_errs", 32'(ferr_cycles - ferr_before + perr_cycles - perr_before), 32'h0);

      // Bad stop bit, line held low, then recovery.
      ferr_before = ferr_cycles;
      apply_stimulus(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (40) @(negedge clk);
      check_output("break_one_frame_err", 32'(ferr_cycles - ferr_before), 32'h1);
      check_output("break_no_valid", 32'(data_valid), 32'h0);
      check_output("break_busy_held", 32'(busy), 32'h1);
      data_bit = 1'b1;
      repeat (6) @(negedge clk);
      check_output("break_released", 32'(busy), 32'h0);
      repeat (10) @(negedge clk);
      apply_stimulus(8'h12, 1'b0, 1'b1, 1'b1, 1'b0);
      repeat (20) @(negedge clk);

      // Reset in the middle of 0xF0 after four data bits.
      data_bit = 1'b0;
      repeat (BIT_CLKS) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         data_bit = 1'b0;
         repeat (BIT_CLKS) @(negedge clk);
      end
      check_output("mid_frame_count", 32'(count), 32'h4);
      check_output("mid_frame_busy", 32'(busy), 32'h1);
      rst_n = 1'b0;
      #1;
      check_output("midrst_data_out", 32'(data_out), 32'h0);
      check_output("midrst_valid", 32'(data_valid), 32'h0);
      check_output("midrst_busy", 32'(busy), 32'h0);
      check_output("midrst_count", 32'(count), 32'h0);
      data_bit = 1'b1;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      apply_stimulus(8'h0F, 1'b0, 1'b1, 1'b1, 1'b0);
      repeat (4) @(negedge clk);
      check_output("after_rst_valid", 32'(data_valid), 32'h1);
      check_output("after_rst_overrun", 32'(overrun), 32'h0);

`ifdef UART_RX_PARITY_EN
      // Even parity: 0x07 has three ones, so the parity bit must be 1.
      pulse_ack();
      perr_before = perr_cycles;
      apply_stimulus(8'h07, 1'b1, 1'b1, 1'b1, 1'b0);
      repeat (4) @(negedge clk);
      check_output("parity_good_no_err", 32'(perr_cycles - perr_before), 32'h0);
      pulse_ack();
      perr_before = perr_cycles;
      apply_stimulus(8'h07, 1'b0, 1'b1, 1'b1, 1'b1);
      repeat (4) @(negedge clk);
      check_output("parity_bad_one_pulse", 32'(perr_cycles - perr_before), 32'h1);
      check_output("parity_bad_valid", 32'(data_valid), 32'h1);
`endif

      repeat (10) @(negedge clk);
      check_output("scoreboard_drained", 32'(exp_q.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
